// File: rtl/panel_key_decoder.sv
// Front-panel keyboard decoder: turns hps_io PS/2 key events into a cursor and
// 25 two-bit switch positions (17 latching toggles, 8 momentary with minimum hold).
module panel_key_decoder #(
  parameter int unsigned HOLD_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  output logic [49:0] switches_status,
  output logic [4:0]  cursor
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_HELD   = 2'd1;
  localparam logic [1:0]  ST_DRAIN  = 2'd2;
  localparam logic [23:0] HOLD_LOAD = 24'(HOLD_CYCLES - 1);
  localparam logic [49:0] SW_RESET  = {16'h0000, {17{2'b10}}};

  localparam logic [1:0]  DIR_UP    = 2'b01;
  localparam logic [1:0]  DIR_DOWN  = 2'b10;

  function automatic logic [4:0] cursor_dec(input logic [4:0] c);
    return (c == 5'd0) ? 5'd24 : c - 5'd1;
  endfunction

  function automatic logic [4:0] cursor_inc(input logic [4:0] c);
    return (c == 5'd24) ? 5'd0 : c + 5'd1;
  endfunction

  logic        tog_q;
  logic        armed_q;
  logic        vld_p0;
  logic [9:0]  key_p0;

  logic [49:0] sw_p1,       sw_n;
  logic [4:0]  cursor_p1,   cursor_n;
  logic [1:0]  state_p1,    state_n;
  logic [23:0] cnt_p1,      cnt_n;
  logic        key_down_p1, key_down_n;
  logic [4:0]  held_idx_p1, held_idx_n;
  logic [1:0]  held_dir_p1, held_dir_n;

  // Stage 0: edge-detect the event toggle and capture the key word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tog_q   <= 1'b0;
      armed_q <= 1'b0;
      vld_p0  <= 1'b0;
    end else begin
      tog_q   <= ps2_key[10];
      armed_q <= 1'b1;
      vld_p0  <= armed_q && (ps2_key[10] != tog_q);
    end
  end

  always_ff @(posedge clk) begin
    key_p0 <= ps2_key[9:0];
  end

  logic       k_press, k_ext;
  logic [7:0] k_code;
  logic       is_left, is_right, is_up, is_down, is_home, is_space;
  logic [5:0] cur_slot, held_slot;
  logic [7:0] held_code;

  always_comb begin
    k_press   = key_p0[9];
    k_ext     = key_p0[8];
    k_code    = key_p0[7:0];
    is_left   = k_ext  && (k_code == 8'h6B);
    is_right  = k_ext  && (k_code == 8'h74);
    is_up     = k_ext  && (k_code == 8'h75);
    is_down   = k_ext  && (k_code == 8'h72);
    is_home   = k_ext  && (k_code == 8'h6C);
    is_space  = !k_ext && (k_code == 8'h29);
    cur_slot  = {cursor_p1, 1'b0};
    held_slot = {held_idx_p1, 1'b0};
    held_code = (held_dir_p1 == DIR_UP) ? 8'h75 : 8'h72;
  end

  // Stage 1: cursor, switch positions and the momentary-hold FSM
  always_comb begin
    sw_n       = sw_p1;
    cursor_n   = cursor_p1;
    state_n    = state_p1;
    cnt_n      = cnt_p1;
    key_down_n = key_down_p1;
    held_idx_n = held_idx_p1;
    held_dir_n = held_dir_p1;

    if (state_p1 != ST_IDLE && cnt_p1 != 24'd0)
      cnt_n = cnt_p1 - 24'd1;

    if (state_p1 == ST_DRAIN && cnt_p1 == 24'd0) begin
      sw_n[held_slot +: 2] = 2'b00;
      state_n              = ST_IDLE;
    end

    if (vld_p0) begin
      if (k_press) begin
        if (is_left)  cursor_n = cursor_dec(cursor_p1);
        if (is_right) cursor_n = cursor_inc(cursor_p1);
        if (is_home)  cursor_n = 5'd0;
      end

      if (state_p1 == ST_IDLE && k_press) begin
        if (cursor_p1 <= 5'd16) begin
          if (is_up)    sw_n[cur_slot +: 2] = DIR_UP;
          if (is_down)  sw_n[cur_slot +: 2] = DIR_DOWN;
          if (is_space) sw_n[cur_slot +: 2] =
                          (sw_p1[cur_slot +: 2] == DIR_UP) ? DIR_DOWN : DIR_UP;
        end else if (is_up || is_down) begin
          held_idx_n           = cursor_p1;
          held_dir_n           = is_up ? DIR_UP : DIR_DOWN;
          sw_n[cur_slot +: 2]  = is_up ? DIR_UP : DIR_DOWN;
          cnt_n                = HOLD_LOAD;
          key_down_n           = 1'b1;
          state_n              = ST_HELD;
        end
      end else if (state_p1 == ST_HELD && key_down_p1 && !k_press &&
                   k_ext && (k_code == held_code)) begin
        key_down_n = 1'b0;
        if (cnt_p1 == 24'd0) begin
          sw_n[held_slot +: 2] = 2'b00;
          state_n              = ST_IDLE;
        end else begin
          state_n = ST_DRAIN;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_p1       <= SW_RESET;
      cursor_p1   <= 5'd0;
      state_p1    <= ST_IDLE;
      cnt_p1      <= 24'd0;
      key_down_p1 <= 1'b0;
    end else begin
      sw_p1       <= sw_n;
      cursor_p1   <= cursor_n;
      state_p1    <= state_n;
      cnt_p1      <= cnt_n;
      key_down_p1 <= key_down_n;
    end
  end

  always_ff @(posedge clk) begin
    held_idx_p1 <= held_idx_n;
    held_dir_p1 <= held_dir_n;
  end

  assign switches_status = sw_p1;
  assign cursor          = cursor_p1;

endmodule

// File: tb/tb_panel_key_decoder.sv
// Scoreboard bench for panel_key_decoder with HOLD_CYCLES=8: stimulus queues
// cycle-tagged expectations, a negedge monitor compares them against the outputs.
module tb_panel_key_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [49:0] switches_status;
  logic [4:0]  cursor;

  panel_key_decoder #(.HOLD_CYCLES(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .ps2_key         (ps2_key),
    .switches_status (switches_status),
    .cursor          (cursor)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [49:0] sw;
    logic [4:0]  cur;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          compared = 0;
  int          mismatched = 0;

  logic [49:0] base, s, t;
  logic [4:0]  c, cc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc <= cyc) begin
        compared++;
        if (switches_status !== sb[i].sw || cursor !== sb[i].cur) begin
          mismatched++;
          $display("FAIL %s @cyc %0d: got switches=%h cursor=%0d, want switches=%h cursor=%0d",
                   sb[i].name, cyc, switches_status, cursor, sb[i].sw, sb[i].cur);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic pr, input logic ex, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ex, code};
  endtask

  task automatic exp_at(input int unsigned off, input string name,
                        input logic [49:0] sw, input logic [4:0] cur);
    exp_t e;
    e.cyc  = cyc + off;
    e.name = name;
    e.sw   = sw;
    e.cur  = cur;
    sb.push_back(e);
  endtask

  initial begin
    base = '0;
    for (int i = 0; i < 17; i++) base[2*i +: 2] = 2'b10;
    s = base;
    c = 5'd0;
    reset   = 1'b1;
    ps2_key = 11'h000;

    tick(2);
    exp_at(1, "reset_state", s, c);
    tick(2);

    // toggle bit already set when reset releases: must not count as an event
    ps2_key = {1'b1, 1'b1, 1'b1, 8'h74};
    reset   = 1'b0;
    for (int off = 1; off <= 4; off++) exp_at(off, "deassert_no_event", s, c);
    tick(5);

    repeat (3) begin
      send(1, 1, 8'h74); c = c + 5'd1; exp_at(2, "right", s, c); tick(2);
    end
    send(1, 1, 8'h75); s[7:6] = 2'b01; exp_at(2, "up_toggle3", s, c); tick(2);
    send(0, 1, 8'h75); exp_at(2, "up_release_ignored", s, c); tick(2);

    send(1, 1, 8'h6C); c = 5'd0;  exp_at(2, "home", s, c); tick(2);
    send(1, 1, 8'h6B); c = 5'd24; exp_at(2, "left_wrap", s, c); tick(2);
    send(1, 1, 8'h74); c = 5'd0;  exp_at(2, "right_wrap", s, c); tick(2);
    repeat (6) begin
      send(1, 1, 8'h6B); c = (c == 5'd0) ? 5'd24 : c - 5'd1;
      exp_at(2, "left_to_19", s, c); tick(2);
    end

    send(1, 0, 8'h29); exp_at(2, "space_momentary", s, c); tick(2);

    // switch 19 Up: exactly 8 cycles of 01 despite early release and a repeat press
    send(1, 1, 8'h75);
    for (int off = 2; off <= 12; off++) begin
      t = s;
      if (off <= 9) t[39:38] = 2'b01;
      exp_at(off, "hold_min_19", t, c);
    end
    tick(2); send(0, 1, 8'h75);
    tick(2); send(1, 1, 8'h75);
    tick(2); send(0, 1, 8'h75);
    tick(7);

    send(1, 1, 8'h74); c = 5'd20; exp_at(2, "right_to_20", s, c); tick(2);

    // switch 20 Down held 20 cycles while the cursor moves on
    send(1, 1, 8'h72);
    for (int off = 2; off <= 24; off++) begin
      t = s;
      if (off <= 21) t[41:40] = 2'b10;
      cc = (off < 4) ? 5'd20 : (off < 6) ? 5'd21 : 5'd22;
      exp_at(off, "hold_long_20", t, cc);
    end
    tick(2); send(1, 1, 8'h74);
    tick(2); send(1, 1, 8'h74);
    tick(2); send(1, 1, 8'h75);
    tick(2); send(0, 1, 8'h75);
    tick(12); send(0, 1, 8'h72);
    tick(5);
    c = 5'd22;

    repeat (6) begin
      send(1, 1, 8'h6B); c = c - 5'd1; exp_at(2, "left_to_16", s, c); tick(2);
    end
    send(1, 0, 8'h29); s[33:32] = 2'b01; exp_at(2, "space16_a", s, c); tick(2);
    send(1, 0, 8'h29); s[33:32] = 2'b10; exp_at(2, "space16_b", s, c); tick(2);
    send(1, 0, 8'h75); exp_at(2, "keypad8_ignored", s, c); tick(2);
    send(1, 1, 8'h75); s[33:32] = 2'b01; exp_at(2, "up16", s, c); tick(2);

    repeat (4) begin
      send(1, 1, 8'h6B); c = c - 5'd1; exp_at(2, "left_to_12", s, c); tick(2);
    end
    send(1, 1, 8'h6C); c = 5'd0; exp_at(2, "home_from_12", s, c); tick(2);

    repeat (8) begin
      send(1, 1, 8'h6B); c = (c == 5'd0) ? 5'd24 : c - 5'd1;
      exp_at(2, "left_to_17", s, c); tick(2);
    end
    send(1, 1, 8'h72); t = s; t[35:34] = 2'b10; exp_at(2, "hold17", t, c);
    tick(3);

    // asynchronous reset in the middle of the hold
    @(posedge clk); #1;
    reset = 1'b1;
    s = base; c = 5'd0;
    exp_at(0, "reset_midhold", s, c);
    tick(3);

    ps2_key = {~ps2_key[10], 1'b1, 1'b1, 8'h74};
    reset   = 1'b0;
    for (int off = 1; off <= 4; off++) exp_at(off, "deassert_toggled", s, c);
    tick(5);
    send(1, 1, 8'h74); c = 5'd1; exp_at(2, "right_after_reset", s, c);
    tick(3);

    for (int w = 0; w < 50 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
      compared   += sb.size();
      mismatched += sb.size();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
